alu_mult_sequencer: RTL and testbench
=====================================

Name: alu_mult_sequencer

Overview:
- Owns the single shared 32-bit ALU in the EX stage.
- Arbitrates the ALU between the pipeline's EX operations and an iterative shift-add unsigned multiplier (MULTU).
- The multiplier borrows the ALU's ADD function for 32 cycles and writes HI/LO.
- While the multiplier owns the ALU, it stalls the pipeline if EX needs the ALU.

Parameters:
FUNCT_ADD, 6'b100000, ALU Signal code driven during multiply iterations
CNT_W, 6, iteration counter width (must hold 0..32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
exValid  input  1  EX stage presents an ALU operation this cycle
exDataA  input  32  EX operand A
exDataB  input  32  EX operand B
exSignal  input  6  EX funct code (ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010)
exDataOut  output  32  ALU result returned to EX (combinational from aluDataOut)
stall  output  1  freeze IF/ID/EX; EX op not executed this cycle
mulStart  input  1  start multiply; sampled only in IDLE
mulA  input  32  multiplicand
mulB  input  32  multiplier
mulBusy  output  1  sequencer not IDLE
mulDone  output  1  one-cycle pulse; hiOut/loOut valid
hiOut  output  32  product bits 63:32
loOut  output  32  product bits 31:0
aluDataA  output  32  to ALU dataA
aluDataB  output  32  to ALU dataB
aluSignal  output  6  to ALU Signal
aluDataOut  input  32  from ALU dataOut

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset values: state IDLE, counter 0, hiOut 0, loOut 0, multiplicand reg 0, mulBusy 0, mulDone 0, stall 0.
- Reset mid-operation aborts the multiply with no mulDone.
- States:
  - IDLE: ALU muxed to EX (aluDataA/B/Signal = exDataA/B/exSignal); stall=0. mulStart=1 -> RUN: HI<=0, LO<=mulB, MCAND<=mulA, cnt<=0. The EX op issued in the start cycle still executes normally.
  - RUN: ALU muxed to sequencer (aluDataA=HI, aluDataB=MCAND, aluSignal=FUNCT_ADD). stall = exValid.
    - Per cycle, carry c = (aluDataOut < MCAND), unsigned local compare (the ALU exposes no carry).
    - If LO[0]=1: HI<={c,aluDataOut[31:1]}, LO<={aluDataOut[0],LO[31:1]}.
    - Else: HI<={1'b0,HI[31:1]}, LO<={HI[0],LO[31:1]}.
    - cnt++; when cnt==31 on this edge -> DONE.
  - DONE: mulDone=1 for exactly one cycle; ALU returned to EX; stall=0 -> IDLE.
- mulBusy=1 in RUN and DONE.
- Latency: the mulStart sampling edge plus 32 RUN edges; mulDone high in the 34th cycle counting the start cycle as 1.
- hiOut/loOut are the live HI/LO registers: they change during RUN and hold after DONE until the next start.
- mulStart outside IDLE is ignored, with no queuing.
- exDataOut = aluDataOut always; EX must disregard it while stall=1.
- Operands 0 and 0xFFFFFFFF need no special casing; the carry compare covers overflow.

Optional Feature:
- SIGNED_MULT_EN defined:
  - Adds input mulSigned (1 bit).
  - At start with mulSigned=1: MCAND/LO load |mulA|/|mulB|, and neg<=mulA[31]^mulB[31].
  - Extra state FIX between RUN and DONE: if neg, {HI,LO}<=-{HI,LO} (64-bit two's complement, local logic, not the ALU). Otherwise FIX holds the registers.
  - mulDone is one cycle later (35th cycle).
  - |0x80000000| is treated as unsigned 0x80000000.
- Undefined: no mulSigned port, no FIX state, unsigned only.

Decomposition:
- Shared package/include: funct constants (FUNCT_ADD/SUB/AND/OR/SLT/MULTU) and state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2, FIX=2'd3.
- One natural sub-module: mult_shift_step, the combinational carry compare plus HI/LO next-value shift. The FSM, counter and ALU mux stay in the top.

Test Plan:
- IDLE passthrough: exValid=1, exDataA=7, exDataB=9, exSignal=100000 -> exDataOut=16 same cycle, stall=0, mulBusy=0.
- mulA=3, mulB=5, mulStart pulse -> mulDone in cycle 34, hiOut=0x00000000, loOut=0x0000000F, then mulBusy=0.
- mulA=mulB=0xFFFFFFFF -> hiOut=0xFFFFFFFE, loOut=0x00000001 (exercises the carry path every iteration).
- exValid=1 held during RUN -> stall=1 every RUN cycle and 0 in the DONE cycle; aluSignal=100000 throughout RUN. Also assert mulStart mid-RUN -> ignored, result unchanged.
- rst_n=0 at RUN iteration 10 -> next cycle mulBusy=0, hiOut=loOut=0, stall=0, mulDone never pulses.
- With SIGNED_MULT_EN, mulSigned=1, mulA=-3, mulB=5 -> cycle 35 mulDone, hiOut=0xFFFFFFFF, loOut=0xFFFFFFF1.

Source files
------------

// File: rtl/alu_mult_sequencer_pkg.sv
// rtl/alu_mult_sequencer_pkg.sv - funct codes, FSM encoding and helpers for the ALU/multiplier sequencer
package alu_mult_sequencer_pkg;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_e;

  // 0x80000000 maps to itself, read back as unsigned magnitude
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// rtl/alu_mult_sequencer_if.sv - EX, multiplier and ALU signal bundle; mulSigned exists only with SIGNED_MULT_EN
interface alu_mult_sequencer_if;

  logic        exValid;
  logic [31:0] exDataA;
  logic [31:0] exDataB;
  logic [5:0]  exSignal;
  logic [31:0] exDataOut;
  logic        stall;
  logic        mulStart;
  logic [31:0] mulA;
  logic [31:0] mulB;
`ifdef SIGNED_MULT_EN
  logic        mulSigned;
`endif
  logic        mulBusy;
  logic        mulDone;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic [31:0] aluDataA;
  logic [31:0] aluDataB;
  logic [5:0]  aluSignal;
  logic [31:0] aluDataOut;

  modport slave (
`ifdef SIGNED_MULT_EN
    input  mulSigned,
`endif
    input  exValid, exDataA, exDataB, exSignal, mulStart, mulA, mulB, aluDataOut,
    output exDataOut, stall, mulBusy, mulDone, hiOut, loOut, aluDataA, aluDataB, aluSignal
  );

  modport master (
`ifdef SIGNED_MULT_EN
    output mulSigned,
`endif
    output exValid, exDataA, exDataB, exSignal, mulStart, mulA, mulB, aluDataOut,
    input  exDataOut, stall, mulBusy, mulDone, hiOut, loOut, aluDataA, aluDataB, aluSignal
  );

endinterface

// File: rtl/alu_mult_sequencer_mult_shift_step.sv
// rtl/alu_mult_sequencer_mult_shift_step.sv - one shift-add iteration: carry recovery and HI/LO shift
module mult_shift_step (
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] sum_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic carry;

  // The ALU has no carry out; a wrapped sum is always smaller than either addend
  assign carry = (sum_i < mcand_i);

  always_comb begin
    if (lo_i[0]) begin
      hi_o = {carry, sum_i[31:1]};
      lo_o = {sum_i[0], lo_i[31:1]};
    end else begin
      hi_o = {1'b0, hi_i[31:1]};
      lo_o = {hi_i[0], lo_i[31:1]};
    end
  end

endmodule

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shares the EX ALU with a 32-cycle shift-add multiplier; SIGNED_MULT_EN adds signed mode
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  alu_mult_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [31:0]      step_hi, step_lo;
  logic [31:0]      load_a, load_b;
  logic             neg_q, neg_d;

`ifdef SIGNED_MULT_EN
  assign load_a = bus.mulSigned ? abs32(bus.mulA) : bus.mulA;
  assign load_b = bus.mulSigned ? abs32(bus.mulB) : bus.mulB;
`else
  assign load_a = bus.mulA;
  assign load_b = bus.mulB;
`endif

  mult_shift_step u_step (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .mcand_i (mcand_q),
    .sum_i   (bus.aluDataOut),
    .hi_o    (step_hi),
    .lo_o    (step_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (bus.mulStart) begin
        state_d = RUN;
        hi_d    = '0;
        lo_d    = load_b;
        mcand_d = load_a;
        cnt_d   = '0;
`ifdef SIGNED_MULT_EN
        neg_d   = bus.mulSigned & (bus.mulA[31] ^ bus.mulB[31]);
`else
        neg_d   = 1'b0;
`endif
      end
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(31)) begin
`ifdef SIGNED_MULT_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SIGNED_MULT_EN
      FIX: begin
        state_d = DONE;
        if (neg_q) {hi_d, lo_d} = 64'd0 - {hi_q, lo_q};
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Only RUN borrows the ALU; every other state hands it straight back to EX
  always_comb begin
    bus.aluDataA  = bus.exDataA;
    bus.aluDataB  = bus.exDataB;
    bus.aluSignal = bus.exSignal;
    bus.stall     = 1'b0;
    if (state_q == RUN) begin
      bus.aluDataA  = hi_q;
      bus.aluDataB  = mcand_q;
      bus.aluSignal = FUNCT_ADD;
      bus.stall     = bus.exValid;
    end
    bus.mulBusy = (state_q != IDLE);
    bus.mulDone = (state_q == DONE);
  end

  assign bus.exDataOut = bus.aluDataOut;
  assign bus.hiOut     = hi_q;
  assign bus.loOut     = lo_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - directed bench with a cycle-level product model for alu_mult_sequencer
module tb_alu_mult_sequencer;

`ifdef SIGNED_MULT_EN
  localparam int LAST = 34;
`else
  localparam int LAST = 33;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_mult_sequencer_if bus ();

  alu_mult_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    case (f)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  always_comb bus.aluDataOut = alu_ref(bus.aluDataA, bus.aluDataB, bus.aluSignal);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph counts cycles since the start edge; after k iterations {HI,LO} is the
  // partial product of the low k multiplier bits above the unconsumed multiplier bits.
  int          ph = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [63:0] held = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph   <= 0;
      held <= '0;
    end else if (ph == 0) begin
      if (bus.mulStart) begin
        ph  <= 1;
        m_a <= bus.mulA;
        m_b <= bus.mulB;
      end
    end else if (ph == LAST) begin
      ph   <= 0;
      held <= 64'(m_a) * 64'(m_b);
    end else begin
      ph <= ph + 1;
    end
  end

  function automatic logic [63:0] exp_val(input int p);
    int          it;
    logic [31:0] mask;
    if (p == 0) return held;
    it = (p - 1 > 32) ? 32 : p - 1;
    if (it == 32) return 64'(m_a) * 64'(m_b);
    mask = (32'd1 << it) - 32'd1;
    return ((64'(m_a) * 64'(m_b & mask)) << (32 - it)) | 64'(m_b >> it);
  endfunction

  always @(negedge clk) begin
    logic in_run;
    logic [63:0] ev;
    in_run = (ph >= 1 && ph <= 32);
    ev = exp_val(ph);
    check("m_hilo", {bus.hiOut, bus.loOut}, ev);
    check("m_stall", 64'(bus.stall), 64'(bus.exValid && in_run));
    check("m_busy", 64'(bus.mulBusy), 64'(ph != 0));
    check("m_done", 64'(bus.mulDone), 64'(ph == LAST));
    if (in_run) begin
      check("m_alu_sig", 64'(bus.aluSignal), 64'(6'b100000));
      check("m_alu_a", 64'(bus.aluDataA), 64'(ev[63:32]));
      check("m_alu_b", 64'(bus.aluDataB), 64'(m_a));
    end else begin
      check("m_alu_sig", 64'(bus.aluSignal), 64'(bus.exSignal));
      check("m_exout", 64'(bus.exDataOut), 64'(alu_ref(bus.exDataA, bus.exDataB, bus.exSignal)));
    end
  end

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit ex_hold,
                         input bit mid_start, output int cyc, output int stall_cnt);
    bit got;
    bus.mulA = a;
    bus.mulB = b;
    bus.mulStart = 1'b1;
    cyc = 1;
    stall_cnt = 0;
    got = 1'b0;
    @(posedge clk); #1;
    bus.mulStart = 1'b0;
    bus.exValid = ex_hold;
    bus.exDataA = 32'd11;
    bus.exDataB = 32'd22;
    bus.exSignal = 6'b100100;
    for (int i = 0; i < 60 && !got; i++) begin
      cyc++;
      if (mid_start && cyc == 10) begin
        bus.mulStart = 1'b1;
        bus.mulA = 32'd100;
        bus.mulB = 32'd100;
      end else begin
        bus.mulStart = 1'b0;
      end
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if (bus.mulDone) begin
        got = 1'b1;
        check("done_stall", 64'(bus.stall), 64'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.exValid = 1'b0;
    @(negedge clk);
    check("busy_after", 64'(bus.mulBusy), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct { logic [31:0] a; logic [31:0] b; logic [5:0] f; logic [31:0] r; } ex_vec_t;
  ex_vec_t ex_vecs[5] = '{
    '{32'd7, 32'd9, 6'b100000, 32'd16},
    '{32'd9, 32'd7, 6'b100010, 32'd2},
    '{32'hC, 32'hA, 6'b100100, 32'h8},
    '{32'hC, 32'hA, 6'b100101, 32'hE},
    '{32'hFFFFFFFF, 32'd1, 6'b101010, 32'd1}
  };

  initial begin
    int cyc, sc, dones;
    bus.exValid = 1'b0;
    bus.exDataA = '0;
    bus.exDataB = '0;
    bus.exSignal = 6'b100000;
    bus.mulStart = 1'b0;
    bus.mulA = '0;
    bus.mulB = '0;
`ifdef SIGNED_MULT_EN
    bus.mulSigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.mulBusy), 64'd0);
    check("rst_done", 64'(bus.mulDone), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_hilo", {bus.hiOut, bus.loOut}, 64'd0);
    rst_n = 1'b1;

    foreach (ex_vecs[i]) begin
      bus.exValid = 1'b1;
      bus.exDataA = ex_vecs[i].a;
      bus.exDataB = ex_vecs[i].b;
      bus.exSignal = ex_vecs[i].f;
      #1;
      check("pass_out", 64'(bus.exDataOut), 64'(ex_vecs[i].r));
      check("pass_stall", 64'(bus.stall), 64'd0);
      @(posedge clk); #1;
    end
    bus.exValid = 1'b0;

    do_mult(32'd3, 32'd5, 1'b0, 1'b0, cyc, sc);
    check("m35_cycle", 64'(cyc), 64'(LAST + 1));
    check("m35_hi", 64'(bus.hiOut), 64'h0);
    check("m35_lo", 64'(bus.loOut), 64'hF);

    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, cyc, sc);
    check("mff_cycle", 64'(cyc), 64'(LAST + 1));
    check("mff_hi", 64'(bus.hiOut), 64'hFFFFFFFE);
    check("mff_lo", 64'(bus.loOut), 64'h1);

    do_mult(32'd3, 32'd5, 1'b1, 1'b1, cyc, sc);
    check("hold_stall_cnt", 64'(sc), 64'd32);
    check("hold_hi", 64'(bus.hiOut), 64'h0);
    check("hold_lo", 64'(bus.loOut), 64'hF);

    bus.mulA = 32'd1234;
    bus.mulB = 32'd5678;
    bus.mulStart = 1'b1;
    @(posedge clk); #1;
    bus.mulStart = 1'b0;
    bus.exValid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(bus.mulBusy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 64'(bus.mulBusy), 64'd0);
    check("abort_hilo", {bus.hiOut, bus.loOut}, 64'd0);
    check("abort_stall", 64'(bus.stall), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.mulDone) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    bus.exValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
